// File: rtl/cache_flush_sequencer.sv
// Walks every cache set on a flush request and writes back each valid dirty way via WbReq/WbAck.
// Define CACHE_FLUSH_INVALIDATE_EN to also clear valid bits, leaving the cache empty after DONE.
module cache_flush_sequencer #(
   parameter int unsigned NUMWAYS  = 4,
   parameter int unsigned SETLEN   = 7,
   parameter int unsigned NUMLINES = 128
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_flush_req,
   output logic               o_flush_busy,
   output logic               o_flush_done,
   output logic [SETLEN-1:0]  o_flush_adr,
   output logic [NUMWAYS-1:0] o_flush_way,
   output logic               o_array_rd_en,
   input  logic [NUMWAYS-1:0] i_valid_way,
   input  logic [NUMWAYS-1:0] i_dirty_way,
   output logic               o_wb_req,
   input  logic               i_wb_ack,
   output logic               o_clear_dirty,
   output logic               o_clear_valid
);

   typedef enum logic [3:0] {
      StIdle,
      StRead,
      StCheck,
      StSel,
      StWb,
      StClr,
      StNext,
`ifdef CACHE_FLUSH_INVALIDATE_EN
      StInv,
`endif
      StDone
   } state_e;

   localparam logic [SETLEN-1:0] LastSet = SETLEN'(NUMLINES - 1);

   state_e             r_state, w_state_next;
   logic [SETLEN-1:0]  r_count, w_count_next;
   logic [NUMWAYS-1:0] r_mask, w_mask_next;
   logic [NUMWAYS-1:0] r_way, w_way_next;
   logic [NUMWAYS-1:0] w_mask_low;
   logic               w_advance;
`ifdef CACHE_FLUSH_INVALIDATE_EN
   logic [NUMWAYS-1:0] r_valid, w_valid_next;
   logic [NUMWAYS-1:0] w_valid_low;

   assign w_valid_low = r_valid & (~r_valid + NUMWAYS'(1));
`endif

   // Two's-complement trick isolates the lowest set bit.
   assign w_mask_low   = r_mask & (~r_mask + NUMWAYS'(1));
   assign o_flush_adr  = r_count;
   assign o_flush_busy = (r_state != StIdle);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_count <= '0;
         r_mask  <= '0;
         r_way   <= '0;
`ifdef CACHE_FLUSH_INVALIDATE_EN
         r_valid <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_mask  <= w_mask_next;
         r_way   <= w_way_next;
`ifdef CACHE_FLUSH_INVALIDATE_EN
         r_valid <= w_valid_next;
`endif
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_mask_next   = r_mask;
      w_way_next    = r_way;
`ifdef CACHE_FLUSH_INVALIDATE_EN
      w_valid_next  = r_valid;
`endif
      w_advance     = 1'b0;
      o_flush_way   = '0;
      o_array_rd_en = 1'b0;
      o_wb_req      = 1'b0;
      o_clear_dirty = 1'b0;
      o_clear_valid = 1'b0;
      o_flush_done  = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (i_flush_req) begin
               w_state_next = StRead;
               w_count_next = '0;
            end
         end
         StRead: begin
            o_array_rd_en = 1'b1;
            w_state_next  = StCheck;
         end
         StCheck: begin
            w_mask_next  = i_valid_way & i_dirty_way;
`ifdef CACHE_FLUSH_INVALIDATE_EN
            w_valid_next = i_valid_way;
`endif
            w_state_next = ((i_valid_way & i_dirty_way) != '0) ? StSel : StNext;
         end
         StSel: begin
            o_flush_way  = w_mask_low;
            w_way_next   = w_mask_low;
            w_state_next = StWb;
         end
         StWb: begin
            o_flush_way = r_way;
            o_wb_req    = 1'b1;
            if (i_wb_ack) begin
               w_state_next = StClr;
            end
         end
         StClr: begin
            o_flush_way   = r_way;
            o_clear_dirty = 1'b1;
`ifdef CACHE_FLUSH_INVALIDATE_EN
            o_clear_valid = 1'b1;
            w_valid_next  = r_valid & ~r_way;
`endif
            w_mask_next   = r_mask & ~r_way;
            w_state_next  = ((r_mask & ~r_way) != '0) ? StSel : StNext;
         end
         StNext: begin
`ifdef CACHE_FLUSH_INVALIDATE_EN
            // Dirty ways were already invalidated in StClr; only clean valid ways remain.
            if (r_valid != '0) begin
               w_state_next = StInv;
            end else begin
               w_advance = 1'b1;
            end
`else
            w_advance = 1'b1;
`endif
         end
`ifdef CACHE_FLUSH_INVALIDATE_EN
         StInv: begin
            o_flush_way   = w_valid_low;
            o_clear_valid = 1'b1;
            w_valid_next  = r_valid & ~w_valid_low;
            if ((r_valid & ~w_valid_low) == '0) begin
               w_advance = 1'b1;
            end
         end
`endif
         StDone: begin
            o_flush_done = 1'b1;
            w_count_next = '0;
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase

      if (w_advance) begin
         if (r_count == LastSet) begin
            w_state_next = StDone;
         end else begin
            w_count_next = r_count + SETLEN'(1);
            w_state_next = StRead;
         end
      end
   end

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Scoreboard bench for cache_flush_sequencer: expected write-back/clear/done events are queued
// from a per-set cache image and popped by an independent monitor.
module tb_cache_flush_sequencer;

   localparam int NW = 4;
   localparam int SL = 7;
   localparam int NL = 128;

   localparam int EvWb   = 1;
   localparam int EvCd   = 2;
   localparam int EvCv   = 3;
   localparam int EvDone = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush_req = 1'b0;
   logic          busy, done, rd_en, wb_req, cd, cv;
   logic          ack = 1'b0;
   logic [SL-1:0] adr;
   logic [NW-1:0] way;
   logic [NW-1:0] vway = '0;
   logic [NW-1:0] dway = '0;

   always #5 clk = ~clk;

   cache_flush_sequencer #(
      .NUMWAYS (NW),
      .SETLEN  (SL),
      .NUMLINES(NL)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_flush_req  (flush_req),
      .o_flush_busy (busy),
      .o_flush_done (done),
      .o_flush_adr  (adr),
      .o_flush_way  (way),
      .o_array_rd_en(rd_en),
      .i_valid_way  (vway),
      .i_dirty_way  (dway),
      .o_wb_req     (wb_req),
      .i_wb_ack     (ack),
      .o_clear_dirty(cd),
      .o_clear_valid(cv)
   );

   logic [NW-1:0] mem_v [NL];
   logic [NW-1:0] mem_d [NL];
   int            exp_q [$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;

   // Environment knobs, written only by the main sequence.
   int ack_fixed = -1;
   int ack_max = 2;
   bit junk_ack = 1'b0;
   bit req_noise = 1'b0;
   int start_req = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ev(input int kind, input int set, input int w);
      return (kind << 12) | (set << 4) | w;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic pop_cmp(input string name, input int act);
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: unexpected event 0x%0h with empty scoreboard", name, act);
      end else begin
         check(name, act, exp_q.pop_front());
      end
   endtask

   // Bus, array and requester environment; drives DUT inputs at the falling edge.
   int start_ack = 0;
   int ack_wait = 0;
   int ack_cnt = 0;
   bit prev_req = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         flush_req = 1'b0;
         ack       = 1'b0;
         prev_req  = 1'b0;
      end else begin
         if (start_req != start_ack && !busy) begin
            flush_req = 1'b1;
            start_ack++;
         end else if (req_noise && busy) begin
            flush_req = done || ($urandom_range(0, 4) == 0);
         end else begin
            flush_req = 1'b0;
         end
         if (rd_en) begin
            vway = mem_v[adr];
            dway = mem_d[adr];
         end
         if (wb_req) begin
            if (!prev_req) begin
               ack_wait = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, ack_max));
               ack_cnt  = 0;
            end
            ack = (ack_cnt >= ack_wait);
            ack_cnt++;
         end else begin
            ack = junk_ack && ($urandom_range(0, 3) == 0);
         end
         prev_req = wb_req;
      end
   end

   // Monitor: observes events and checks them against the scoreboard.
   int            n_done = 0;
   int            n_wbcyc = 0;
   int            n_cd = 0;
   int            n_cv = 0;
   int            busy_rise_cyc = 0;
   int            done_cyc = 0;
   int            last_cd_cyc = 0;
   bit            prev_busy = 1'b0;
   bit            prev_wait = 1'b0;
   logic [SL-1:0] prev_adr = '0;
   logic [NW-1:0] prev_way = '0;
   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_busy = 1'b0;
         prev_wait = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            busy_rise_cyc = cyc;
            check("start_adr", int'(adr), 0);
            check("start_rd_en", int'(rd_en), 1);
         end
         if (wb_req) begin
            n_wbcyc++;
            check("wb_way_onehot", int'($onehot(way)), 1);
            if (prev_wait) begin
               check("wb_adr_stable", int'(adr), int'(prev_adr));
               check("wb_way_stable", int'(way), int'(prev_way));
            end
         end
         if (wb_req && ack) pop_cmp("wb_event", ev(EvWb, int'(adr), int'(way)));
         if (cd) begin
            n_cd++;
            last_cd_cyc = cyc;
            pop_cmp("clear_dirty_event", ev(EvCd, int'(adr), int'(way)));
         end
         if (cv) begin
            n_cv++;
            pop_cmp("clear_valid_event", ev(EvCv, int'(adr), int'(way)));
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            pop_cmp("done_event", ev(EvDone, 0, 0));
         end
         prev_busy = busy;
         prev_wait = wb_req && !ack;
         prev_adr  = adr;
         prev_way  = way;
      end
   end

   // Reference: sets in order, dirty ways lowest-first, optional invalidation of the rest.
   task automatic build_expect();
      for (int s = 0; s < NL; s++) begin
         for (int w = 0; w < NW; w++) begin
            if (mem_v[s][w] && mem_d[s][w]) begin
               exp_q.push_back(ev(EvWb, s, 1 << w));
               exp_q.push_back(ev(EvCd, s, 1 << w));
`ifdef CACHE_FLUSH_INVALIDATE_EN
               exp_q.push_back(ev(EvCv, s, 1 << w));
`endif
            end
         end
`ifdef CACHE_FLUSH_INVALIDATE_EN
         for (int w = 0; w < NW; w++) begin
            if (mem_v[s][w] && !mem_d[s][w]) exp_q.push_back(ev(EvCv, s, 1 << w));
         end
`endif
      end
      exp_q.push_back(ev(EvDone, 0, 0));
   endtask

   task automatic fill(input bit rand_valid, input int dirty_odds);
      for (int s = 0; s < NL; s++) begin
         mem_v[s] = rand_valid ? NW'($urandom()) : '0;
         mem_d[s] = (dirty_odds > 0 && $urandom_range(0, dirty_odds - 1) == 0) ? NW'($urandom()) : '0;
      end
   endtask

   // stop_set >= 0: return once WbReq is up on that set instead of waiting for done.
   task automatic run_flush(input int stop_set, input string tag);
      int  d0;
      bit  hit;
      d0  = n_done;
      hit = 1'b0;
      build_expect();
      start_req++;
      for (int i = 0; i < 20000 && !hit; i++) begin
         @(negedge clk);
         #2;
         if (stop_set >= 0) hit = wb_req && (int'(adr) == stop_set);
         else hit = (n_done != d0);
      end
      if (stop_set >= 0) begin
         check({tag, "_reached_wb"}, int'(hit), 1);
      end else begin
         check({tag, "_one_done"}, n_done - d0, 1);
         check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
         exp_q.delete();
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      int wb0, cd0, cv0, d0;
      #1;
      check("reset_outputs", int'({busy, done, adr, way, rd_en, wb_req, cd, cv}), 0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;

      // All-clean walk: 3 cycles per set, no write-back.
      fill(1'b1, 0);
      wb0 = n_wbcyc;
      run_flush(-1, "clean");
      check("clean_cycles", done_cyc - busy_rise_cyc, 3 * NL);
      check("clean_no_wbreq", n_wbcyc - wb0, 0);

      // Set 5: two dirty valid ways served, the invalid dirty way skipped.
      fill(1'b0, 0);
      mem_v[5] = 4'b1011;
      mem_d[5] = 4'b1110;
      ack_fixed = 2;
      cd0 = n_cd;
      run_flush(-1, "set5");
      check("set5_clear_count", n_cd - cd0, 2);

      // Long ack stall on the last set.
      fill(1'b0, 0);
      mem_v[127] = 4'b1000;
      mem_d[127] = 4'b1000;
      ack_fixed = 50;
      wb0 = n_wbcyc;
      run_flush(-1, "tail");
      check("tail_wb_cycles", n_wbcyc - wb0, 51);
      check("tail_done_gap", done_cyc - last_cd_cyc, 2);

      // Reset while waiting in write-back on set 40.
      fill(1'b0, 0);
      mem_v[40] = 4'b1111;
      mem_d[40] = 4'b0100;
      ack_fixed = 1000;
      cd0 = n_cd;
      d0  = n_done;
      run_flush(40, "rst");
      rst = 1'b1;
      #1;
      check("midwb_reset_outputs", int'({busy, done, adr, way, rd_en, wb_req, cd, cv}), 0);
      repeat (2) @(negedge clk);
      exp_q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      check("midwb_no_clear", n_cd - cd0, 0);
      check("midwb_no_done", n_done - d0, 0);
      ack_fixed = 3;
      run_flush(-1, "restart");

      // Set 0 with one dirty way among three valid ones.
      fill(1'b0, 0);
      mem_v[0] = 4'b0111;
      mem_d[0] = 4'b0001;
      ack_fixed = 0;
      cv0 = n_cv;
      run_flush(-1, "inv");
`ifdef CACHE_FLUSH_INVALIDATE_EN
      check("inv_clear_valid_count", n_cv - cv0, 3);
`else
      check("inv_clear_valid_count", n_cv - cv0, 0);
`endif

      // Random images, random ack latency, stray acks; first pass also pokes FlushReq mid-walk.
      ack_fixed = -1;
      ack_max   = 4;
      junk_ack  = 1'b1;
      for (int r = 0; r < 4; r++) begin
         fill(1'b1, 4);
         req_noise = (r == 0);
         d0 = n_done;
         run_flush(-1, "random");
         if (req_noise) begin
            repeat (20) @(negedge clk);
            #2;
            check("noise_single_done", n_done - d0, 1);
            check("noise_back_idle", int'(busy), 0);
            req_noise = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
